// File: rtl/bascomp_io_pkg.sv
// rtl/bascomp_io_pkg.sv - shared widths and FSM state types for the I/O interrupt block
package bascomp_io_pkg;

    localparam int IO_WORD_W   = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic {
        IN_EMPTY = 1'b0,
        IN_FULL  = 1'b1
    } in_state_t;

    typedef enum logic {
        OUT_READY = 1'b0,
        OUT_BUSY  = 1'b1
    } out_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - synchronizer plus rising-edge detector for an asynchronous strobe
module sync_edge_detect
    import bascomp_io_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;

    // fill_q marks when sync_q holds a real sample rather than its reset value; until then
    // prev_q is held high so a strobe already high at reset release never looks like a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            fill_q <= '0;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q <= fill_q[SYNC_STAGES-1] ? sync_q[SYNC_STAGES-1] : 1'b1;
        end
    end

    assign rise_pulse = fill_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/io_interrupt_controller.sv
// rtl/io_interrupt_controller.sv - keyboard/printer flags, IEN and interrupt request (R) logic
// Optional INPUT_OVERRUN_DETECT_EN: unread-byte arrivals are dropped and flagged on sticky overrun.
module io_interrupt_controller
    import bascomp_io_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IO_WORD_W-1:0] keyboard_data,
    input  logic                 input_arrived_flag,
    input  logic                 inp_read,
    input  logic                 out_write,
    input  logic [IO_WORD_W-1:0] out_data,
    input  logic                 output_done,
    input  logic                 ien_set,
    input  logic                 ien_clear,
    input  logic                 int_ack,
    output logic [IO_WORD_W-1:0] inpr,
    output logic                 fgi,
    output logic [IO_WORD_W-1:0] outr,
    output logic                 fgo,
    output logic                 output_valid,
    output logic                 ien,
    output logic                 int_req,
    output logic                 overrun
);

    in_state_t            in_state, in_state_nx;
    out_state_t           out_state, out_state_nx;
    logic [IO_WORD_W-1:0] inpr_nx, outr_nx;
    logic                 ien_nx, int_req_nx, overrun_nx;
    logic                 arrival;

    sync_edge_detect u_sync_edge_detect (
        .clk        (clk),
        .reset      (reset),
        .async_in   (input_arrived_flag),
        .rise_pulse (arrival)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_state  <= IN_EMPTY;
            out_state <= OUT_READY;
            inpr      <= '0;
            outr      <= '0;
            ien       <= 1'b0;
            int_req   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            in_state  <= in_state_nx;
            out_state <= out_state_nx;
            inpr      <= inpr_nx;
            outr      <= outr_nx;
            ien       <= ien_nx;
            int_req   <= int_req_nx;
            overrun   <= overrun_nx;
        end
    end

    always_comb begin
        in_state_nx  = in_state;
        out_state_nx = out_state;
        inpr_nx      = inpr;
        outr_nx      = outr;
        ien_nx       = ien;
`ifdef INPUT_OVERRUN_DETECT_EN
        overrun_nx   = overrun;
`else
        overrun_nx   = 1'b0;
`endif

        // A read in the same cycle as an arrival frees the buffer, so the new byte is kept.
        if (arrival) begin
`ifdef INPUT_OVERRUN_DETECT_EN
            if (in_state == IN_EMPTY || inp_read) begin
                inpr_nx     = keyboard_data;
                in_state_nx = IN_FULL;
            end else begin
                overrun_nx  = 1'b1;
            end
`else
            inpr_nx     = keyboard_data;
            in_state_nx = IN_FULL;
`endif
        end else if (inp_read && in_state == IN_FULL) begin
            in_state_nx = IN_EMPTY;
        end

        if (out_state == OUT_READY && out_write) begin
            outr_nx      = out_data;
            out_state_nx = OUT_BUSY;
        end else if (out_state == OUT_BUSY && output_done) begin
            out_state_nx = OUT_READY;
        end

        if (int_ack || ien_clear) begin
            ien_nx = 1'b0;
        end else if (ien_set) begin
            ien_nx = 1'b1;
        end

        // R latches once a flag is seen with IEN on; only int_ack or IEN going low drops it.
        int_req_nx = ien & ~int_ack & (int_req | fgi | fgo);
    end

    assign fgi          = (in_state == IN_FULL);
    assign fgo          = (out_state == OUT_READY);
    assign output_valid = (out_state == OUT_BUSY);

endmodule
